// File: rtl/mux8_rr_arbiter_if.sv
// Channel bundle for the 8-source round-robin mux arbiter: requests and data in,
// one-hot grant, select, valid and gated data bit out.
interface mux8_rr_arbiter_if;
   logic [7:0] req;
   logic [7:0] data_in;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       valid;
   logic       z;

   modport master (
      output req,
      output data_in,
      input  grant,
      input  sel,
      input  valid,
      input  z
   );

   modport slave (
      input  req,
      input  data_in,
      output grant,
      output sel,
      output valid,
      output z
   );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 8-to-1 single-bit mux channel.
// Define ARB_TIMEOUT_EN to force handoff after MAX_HOLD consecutive grant cycles.
module mux8_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input logic             clk,
   input logic             rst_n,
   mux8_rr_arbiter_if.slave bus
);

   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
      $error("MAX_HOLD must be in 1..15");
   end

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

`ifdef ARB_TIMEOUT_EN
   localparam logic [3:0] HOLD_CAP = 4'(MAX_HOLD);
`else
   localparam logic [3:0] HOLD_CAP = 4'd15;
`endif

   state_t     r_state, w_state_nxt;
   logic [7:0] r_grant, w_grant_nxt;
   logic [2:0] r_sel,   w_sel_nxt;
   logic [2:0] r_ptr,   w_ptr_nxt;
   logic       r_valid, w_valid_nxt;
   logic [3:0] r_hold,  w_hold_nxt;

   logic [7:0] w_mask;
   logic       w_found;
   logic [2:0] w_idx;
   logic       w_release;
   logic       w_timeout;

   // Rotate so the bit just after 'last' lands at position 0, then take the lowest set bit.
   function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] last);
      logic [15:0] dbl;
      logic [7:0]  rot;
      logic        found;
      logic [2:0]  idx;
      dbl   = {mask, mask} >> (4'(last) + 4'd1);
      rot   = dbl[7:0];
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (!found && rot[3'(k)]) begin
            found = 1'b1;
            idx   = last + 3'd1 + 3'(k);
         end
      end
      return {found, idx};
   endfunction

   // In BUSY the pointer equals the owner, so masking the owner out yields the handoff search.
   always_comb begin
      w_mask = (r_state == S_BUSY) ? (bus.req & ~r_grant) : bus.req;
      {w_found, w_idx} = rr_pick(w_mask, r_ptr);
      w_release = ~|(bus.req & r_grant);
`ifdef ARB_TIMEOUT_EN
      w_timeout = (r_hold == HOLD_CAP);
`else
      w_timeout = 1'b0;
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_valid_nxt = r_valid;
      w_hold_nxt  = r_hold;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_BUSY;
               w_grant_nxt = 8'd1 << w_idx;
               w_sel_nxt   = w_idx;
               w_ptr_nxt   = w_idx;
               w_valid_nxt = 1'b1;
               w_hold_nxt  = 4'd1;
            end
         end
         S_BUSY: begin
            if ((w_release || w_timeout) && w_found) begin
               w_grant_nxt = 8'd1 << w_idx;
               w_sel_nxt   = w_idx;
               w_ptr_nxt   = w_idx;
               w_hold_nxt  = 4'd1;
            end else if (w_release) begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = '0;
               w_valid_nxt = 1'b0;
               w_hold_nxt  = '0;
            end else if (r_hold != HOLD_CAP) begin
               w_hold_nxt = r_hold + 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_sel   <= '0;
         r_ptr   <= '1;
         r_valid <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_valid <= w_valid_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   assign bus.grant = r_grant;
   assign bus.sel   = r_sel;
   assign bus.valid = r_valid;
   assign bus.z     = bus.data_in[r_sel] & r_valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed plan steps, then randomized
// traffic with occasional asynchronous resets, checked against a rule-level model.
module tb_mux8_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
   localparam int MH    = 4;
`else
   localparam bit TO_EN = 1'b0;
   localparam int MH    = 8;
`endif

   logic clk;
   logic rst_n;
   mux8_rr_arbiter_if bus ();

   mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state: current owner (-1 = none), pointer, select, hold count.
   int m_owner;
   int m_ptr;
   int m_sel;
   int m_hold;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 7;
      m_sel   = 0;
      m_hold  = 0;
   endtask

   function automatic int first_from(input logic [7:0] r, input int last);
      for (int k = 1; k <= 8; k++) begin
         if (r[(last + k) % 8]) return (last + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_take(input int w);
      m_owner = w;
      m_ptr   = w;
      m_sel   = w;
      m_hold  = 1;
   endtask

   task automatic model_step(input logic [7:0] r);
      int         o;
      int         w;
      logic [7:0] others;
      bit         tmo;
      if (m_owner < 0) begin
         w = first_from(r, m_ptr);
         if (w >= 0) model_take(w);
      end else begin
         o = m_owner;
         others = r;
         others[o] = 1'b0;
         tmo = TO_EN && (m_hold == MH);
         if ((!r[o] || tmo) && others != 8'h00) begin
            model_take(first_from(others, o));
         end else if (!r[o]) begin
            m_owner = -1;
            m_hold  = 0;
         end else if (m_hold < (TO_EN ? MH : 15)) begin
            m_hold++;
         end
      end
   endtask

   task automatic compare_model(input string tag);
      logic [7:0] e_grant;
      logic [7:0] dvec;
      logic       e_z;
      dvec    = bus.data_in;
      e_grant = (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
      e_z     = (m_owner >= 0) && dvec[m_sel];
      check({tag, ".grant"}, bus.grant, e_grant);
      check({tag, ".sel"},   {5'b0, bus.sel}, 8'(m_sel));
      check({tag, ".valid"}, {7'b0, bus.valid}, {7'b0, (m_owner >= 0)});
      check({tag, ".z"},     {7'b0, bus.z}, {7'b0, e_z});
   endtask

   // One clock: the model sees the same req the DUT samples, outputs are checked 1 time unit later.
   task automatic tick(input string tag);
      @(posedge clk);
      model_step(bus.req);
      #1;
      compare_model(tag);
   endtask

   task automatic async_reset_pulse(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check({tag, ".grant"}, bus.grant, 8'h00);
      check({tag, ".valid"}, {7'b0, bus.valid}, 8'h00);
      check({tag, ".z"},     {7'b0, bus.z}, 8'h00);
      check({tag, ".sel"},   {5'b0, bus.sel}, 8'h00);
      rst_n = 1'b1;
   endtask

   logic [7:0] rq;

   initial begin
      model_reset();
      rst_n       = 1'b0;
      bus.req     = 8'h00;
      bus.data_in = 8'h00;
      #2;
      check("rst.grant", bus.grant, 8'h00);
      check("rst.valid", {7'b0, bus.valid}, 8'h00);
      check("rst.sel",   {5'b0, bus.sel}, 8'h00);
      check("rst.z",     {7'b0, bus.z}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // First grant: source 0 beats source 7 straight out of reset.
      bus.req     = 8'h81;
      bus.data_in = 8'h01;
      tick("first");
      check("first.grant_c", bus.grant, 8'h01);
      check("first.z_hi",    {7'b0, bus.z}, 8'h01);
      bus.data_in = 8'hFE;
      #1;
      check("first.z_lo", {7'b0, bus.z}, 8'h00);
      compare_model("first.zfollow");

      // Rotation: everybody requests, each owner drops for one cycle in turn.
      for (int i = 0; i < 8; i++) begin
         bus.req     = 8'hFF & ~(8'd1 << i);
         bus.data_in = 8'($urandom);
         tick("rot");
         check("rot.order", bus.grant, 8'd1 << ((i + 1) % 8));
      end

      // Release to idle, then 5 and 6 together: 6 comes first after 5.
      bus.req     = 8'h20;
      bus.data_in = 8'hFF;
      tick("to5");
      check("to5.grant_c", bus.grant, 8'h20);
      bus.req = 8'h00;
      tick("idle");
      check("idle.grant_c", bus.grant, 8'h00);
      check("idle.sel_c",   {5'b0, bus.sel}, 8'h05);
      check("idle.z_c",     {7'b0, bus.z}, 8'h00);
      bus.req = 8'h60;
      tick("re56");
      check("re56.grant_c", bus.grant, 8'h40);

      // Async reset while source 3 owns the channel with data high.
      bus.req     = 8'h08;
      bus.data_in = 8'h08;
      tick("to3");
      check("to3.z_c", {7'b0, bus.z}, 8'h01);
      async_reset_pulse("arst");
      bus.req = 8'h18;
      tick("post_rst");
      check("post_rst.grant_c", bus.grant, 8'h08);

      // Hold limit with a competitor appearing one cycle after the grant.
      bus.req = 8'h04;
      tick("hold_start");
      check("hold_start.grant_c", bus.grant, 8'h04);
      bus.req = 8'h44;
      for (int i = 0; i < 5; i++) begin
         tick("hold");
         if (TO_EN) check("hold.grant_to", bus.grant, (i < 3) ? 8'h04 : 8'h40);
         else       check("hold.grant_nto", bus.grant, 8'h04);
      end

      // Sole requester is never forced off.
      bus.req = 8'h00;
      tick("drop");
      bus.req = 8'h04;
      tick("solo_start");
      for (int i = 0; i < 10; i++) begin
         tick("solo");
         check("solo.grant_c", bus.grant, 8'h04);
      end

      // Randomized traffic: sticky requests so owners hold for a while, rare async resets.
      rq = 8'($urandom);
      for (int i = 0; i < 600; i++) begin
         rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         bus.req     = rq;
         bus.data_in = 8'($urandom);
         tick("rand");
         if ($urandom_range(0, 59) == 0) async_reset_pulse("rand_rst");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
